// File: rtl/fabric_config_stream.sv
// Fabric configuration loader: 32-bit bitstream words in over valid/ready,
// assembled into per-row frame registers and strobed into one fabric column per frame.
module fabric_config_stream #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 12,
  parameter int NumRows         = 18,
  parameter int StrobeCycles    = 1
) (
  input  logic                                  clk_gated,
  input  logic                                  rst_ni,
  input  logic [31:0]                           data_i,
  input  logic                                  data_valid_i,
  output logic                                  data_ready_o,
  input  logic                                  abort_i,
  output logic                                  busy_o,
  output logic                                  configured_o,
  output logic                                  error_o,
  output logic [15:0]                           frames_o,
  output logic [FrameBitsPerRow*NumRows-1:0]    FrameData_o,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe_o
);

  localparam int StrobeW = MaxFramesPerCol * NumColumns;
  localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int CntW    = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [31:0] StartWord = 32'hFAB0FAB1;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_STROBE, S_CHECK} state_t;

  state_t                     state_reg, state_next;
  logic                       ready_reg;
  logic [4:0]                 col_reg, col_next;
  logic [MaxFramesPerCol-1:0] mask_reg, mask_next;
  logic [RowW-1:0]            row_cnt_reg, row_cnt_next;
  logic [CntW-1:0]            stb_cnt_reg, stb_cnt_next;
  logic [31:0]                csum_reg, csum_next, csum_fold;
  logic                       configured_reg, configured_next;
  logic                       error_reg, error_next;
  logic [15:0]                frames_reg, frames_next;
  logic [StrobeW-1:0]         strobe_reg, strobe_next, strobe_pat;
  logic                       accept, row_wr;
  logic [2:0]                 opcode;

  assign accept    = data_valid_i && ready_reg;
  assign opcode    = data_i[26:24];
  assign csum_fold = {csum_reg[30:0], csum_reg[31]} ^ data_i;

  genvar gi;

  // One-hot column placement of the latched frame mask.
  generate
    for (gi = 0; gi < NumColumns; gi++) begin : g_col
      assign strobe_pat[gi*MaxFramesPerCol +: MaxFramesPerCol] =
        (col_reg == 5'(gi)) ? mask_reg : '0;
    end
  endgenerate

  // Row registers hold their content across abort; only reset clears them.
  generate
    for (gi = 0; gi < NumRows; gi++) begin : g_row
      logic [FrameBitsPerRow-1:0] row_reg;
      always_ff @(posedge clk_gated or negedge rst_ni) begin
        if (!rst_ni) begin
          row_reg <= '0;
        end else if (row_wr && (row_cnt_reg == RowW'(gi))) begin
          row_reg <= data_i;
        end
      end
      assign FrameData_o[gi*FrameBitsPerRow +: FrameBitsPerRow] = row_reg;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    col_next        = col_reg;
    mask_next       = mask_reg;
    row_cnt_next    = row_cnt_reg;
    stb_cnt_next    = stb_cnt_reg;
    csum_next       = csum_reg;
    configured_next = configured_reg;
    error_next      = error_reg;
    frames_next     = frames_reg;
    strobe_next     = '0;
    row_wr          = 1'b0;
    if (abort_i) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept && (data_i == StartWord)) begin
            state_next      = S_HEADER;
            configured_next = 1'b0;
            error_next      = 1'b0;
            frames_next     = '0;
            csum_next       = '0;
          end
        end
        S_HEADER: begin
          if (accept) begin
            csum_next = csum_fold;
            case (opcode)
              3'd0: begin
                if ({27'd0, data_i[31:27]} < 32'(NumColumns)) begin
                  col_next     = data_i[31:27];
                  mask_next    = data_i[MaxFramesPerCol-1:0];
                  row_cnt_next = RowW'(NumRows - 1);
                  state_next   = S_DATA;
                end else begin
                  error_next = 1'b1;
                  state_next = S_IDLE;
                end
              end
              3'd1: begin
                configured_next = 1'b1;
                state_next      = S_IDLE;
              end
              3'd2: state_next = S_CHECK;
              default: begin
                error_next = 1'b1;
                state_next = S_IDLE;
              end
            endcase
          end
        end
        S_DATA: begin
          if (accept) begin
            csum_next = csum_fold;
            row_wr    = 1'b1;
            if (row_cnt_reg == '0) begin
              state_next   = S_STROBE;
              strobe_next  = strobe_pat;
              stb_cnt_next = CntW'(StrobeCycles - 1);
            end else begin
              row_cnt_next = row_cnt_reg - RowW'(1);
            end
          end
        end
        S_STROBE: begin
          if (stb_cnt_reg == '0) begin
            state_next = S_HEADER;
            if (frames_reg != 16'hFFFF) begin
              frames_next = frames_reg + 16'd1;
            end
          end else begin
            stb_cnt_next = stb_cnt_reg - CntW'(1);
            strobe_next  = strobe_pat;
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (data_i != csum_reg) begin
              error_next = 1'b1;
              state_next = S_IDLE;
            end else begin
              state_next = S_HEADER;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_gated or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= S_IDLE;
      ready_reg      <= 1'b0;
      col_reg        <= '0;
      mask_reg       <= '0;
      row_cnt_reg    <= '0;
      stb_cnt_reg    <= '0;
      csum_reg       <= '0;
      configured_reg <= 1'b0;
      error_reg      <= 1'b0;
      frames_reg     <= '0;
      strobe_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      // Ready is registered from the next state so it drops exactly while strobing.
      ready_reg      <= (state_next != S_STROBE);
      col_reg        <= col_next;
      mask_reg       <= mask_next;
      row_cnt_reg    <= row_cnt_next;
      stb_cnt_reg    <= stb_cnt_next;
      csum_reg       <= csum_next;
      configured_reg <= configured_next;
      error_reg      <= error_next;
      frames_reg     <= frames_next;
      strobe_reg     <= strobe_next;
    end
  end

  assign data_ready_o  = ready_reg;
  assign busy_o        = (state_reg != S_IDLE);
  assign configured_o  = configured_reg;
  assign error_o       = error_reg;
  assign frames_o      = frames_reg;
  assign FrameStrobe_o = strobe_reg;

endmodule

// File: tb/tb_fabric_config_stream.sv
// Self-checking bench for fabric_config_stream: table vectors, hand-written corner
// sequences and random streams checked against a word-level reference model.
module tb_fabric_config_stream;

  localparam logic [31:0] START = 32'hFAB0FAB1;
  localparam int P_IDLE = 0, P_HDR = 1, P_DATA = 2, P_CHK = 3;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  data_i = '0;
  logic         valid_m = 1'b0, valid3 = 1'b0, abort = 1'b0;
  logic         ready_m, busy_m, cfg_m, err_m;
  logic [15:0]  frames_m;
  logic [575:0] fdata_m;
  logic [239:0] stb_m;
  logic         ready3, busy3, cfg3, err3;
  logic [15:0]  frames3;
  logic [575:0] fdata3;
  logic [239:0] stb3;

  fabric_config_stream dut (
    .clk_gated(clk), .rst_ni(rst_ni), .data_i(data_i), .data_valid_i(valid_m),
    .data_ready_o(ready_m), .abort_i(abort), .busy_o(busy_m), .configured_o(cfg_m),
    .error_o(err_m), .frames_o(frames_m), .FrameData_o(fdata_m), .FrameStrobe_o(stb_m)
  );

  fabric_config_stream #(.StrobeCycles(3)) dut3 (
    .clk_gated(clk), .rst_ni(rst_ni), .data_i(data_i), .data_valid_i(valid3),
    .data_ready_o(ready3), .abort_i(1'b0), .busy_o(busy3), .configured_o(cfg3),
    .error_o(err3), .frames_o(frames3), .FrameData_o(fdata3), .FrameStrobe_o(stb3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int gap_max  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors sample 1 time unit after the active edge.
  int           mon_stb_cycles = 0, mon3_rdy_low = 0, mon3_stb_high = 0;
  logic [239:0] mon_last_stb = '0, mon3_last_stb = '0;
  always begin
    @(posedge clk);
    #1;
    if (rst_ni) begin
      if (stb_m != '0) begin mon_stb_cycles++; mon_last_stb = stb_m; end
      if (!ready3) mon3_rdy_low++;
      if (stb3 != '0) begin mon3_stb_high++; mon3_last_stb = stb3; end
    end
  end

  // Word-level reference model: consumes the accepted word sequence of the main DUT.
  int           m_phase, m_row, m_col, m_nstb;
  logic         m_cfg, m_err;
  logic [15:0]  m_frames;
  logic [31:0]  m_c;
  logic [19:0]  m_mask;
  logic [31:0]  m_rows [18];
  logic [239:0] m_last_stb;

  function automatic logic [31:0] fold(input logic [31:0] c, input logic [31:0] w);
    return {c[30:0], c[31]} ^ w;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_row = 0; m_col = 0; m_nstb = 0; m_cfg = 0; m_err = 0;
    m_frames = 0; m_c = 0; m_mask = 0; m_last_stb = '0;
    for (int i = 0; i < 18; i++) m_rows[i] = '0;
  endtask

  task automatic model_word(input logic [31:0] w);
    case (m_phase)
      P_IDLE: if (w == START) begin
        m_phase = P_HDR; m_cfg = 0; m_err = 0; m_frames = 0; m_c = 0;
      end
      P_HDR: begin
        m_c = fold(m_c, w);
        if (w[26:24] == 3'd0 && int'(w[31:27]) < 12) begin
          m_col = int'(w[31:27]); m_mask = w[19:0]; m_row = 17; m_phase = P_DATA;
        end else if (w[26:24] == 3'd1) begin
          m_cfg = 1; m_phase = P_IDLE;
        end else if (w[26:24] == 3'd2) begin
          m_phase = P_CHK;
        end else begin
          m_err = 1; m_phase = P_IDLE;
        end
      end
      P_DATA: begin
        m_c = fold(m_c, w);
        m_rows[m_row] = w;
        if (m_row == 0) begin
          if (m_frames != 16'hFFFF) m_frames = m_frames + 16'd1;
          m_last_stb = '0;
          m_last_stb[m_col*20 +: 20] = m_mask;
          m_nstb++;
          m_phase = P_HDR;
        end else begin
          m_row--;
        end
      end
      default: begin
        if (w != m_c) begin m_err = 1; m_phase = P_IDLE; end
        else m_phase = P_HDR;
      end
    endcase
  endtask

  function automatic logic [31:0] row_m(input int i);
    return fdata_m[i*32 +: 32];
  endfunction
  function automatic logic [31:0] row3(input int i);
    return fdata3[i*32 +: 32];
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input bit which, input logic [31:0] w);
    bit done = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    data_i = w;
    if (which) valid3 = 1'b1; else valid_m = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      done = which ? ready3 : ready_m;
      @(negedge clk);
    end
    valid_m = 1'b0;
    valid3  = 1'b0;
    chk("send_accept", 256'(done), 256'(1));
    if (done && !which) model_word(w);
  endtask

  task automatic abort_pulse();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    model_reset_phase();
  endtask

  task automatic model_reset_phase();
    m_phase = P_IDLE;
  endtask

  typedef struct {
    logic [31:0] hdr;
    bit          has_pl;
    logic [31:0] pl;
    bit          e_err;
    bit          e_cfg;
    bit          e_busy;
  } vec_t;
  vec_t vecs [8];

  task automatic rand_stream(input int s);
    int           nfr, stb0, nstb0, col;
    logic [31:0]  w;
    logic [19:0]  mask;
    stb0  = mon_stb_cycles;
    nstb0 = m_nstb;
    if ($urandom_range(0, 1) == 1) begin
      w = $urandom();
      if (w == START) w = w ^ 32'h1;
      send(0, w);
    end
    send(0, START);
    nfr = $urandom_range(1, 3);
    for (int f = 0; f < nfr; f++) begin
      col  = $urandom_range(0, 11);
      mask = 20'($urandom_range(1, 20'hFFFFF));
      send(0, {5'(col), 3'd0, 4'd0, mask});
      for (int r = 0; r < 18; r++) send(0, $urandom());
      if ($urandom_range(0, 3) == 0) begin
        send(0, {5'($urandom_range(0, 31)), 3'd2, 24'($urandom())});
        send(0, ($urandom_range(0, 3) == 0) ? (m_c ^ 32'h1) : m_c);
      end
    end
    case ($urandom_range(0, 3))
      0: send(0, {5'($urandom_range(12, 31)), 3'd0, 24'($urandom())});
      1: send(0, {5'($urandom_range(0, 31)), 3'($urandom_range(3, 7)), 24'($urandom())});
      default: send(0, {5'($urandom_range(0, 31)), 3'd1, 24'($urandom())});
    endcase
    repeat (3) @(negedge clk);
    chk($sformatf("rnd%0d_cfg", s), 256'(cfg_m), 256'(m_cfg));
    chk($sformatf("rnd%0d_err", s), 256'(err_m), 256'(m_err));
    chk($sformatf("rnd%0d_frames", s), 256'(frames_m), 256'(m_frames));
    chk($sformatf("rnd%0d_busy", s), 256'(busy_m), 256'(m_phase != P_IDLE));
    chk($sformatf("rnd%0d_stb_cycles", s), 256'(mon_stb_cycles - stb0), 256'(m_nstb - nstb0));
    if (m_nstb != nstb0) chk($sformatf("rnd%0d_stb_pat", s), 256'(mon_last_stb), 256'(m_last_stb));
    for (int i = 0; i < 18; i++) chk($sformatf("rnd%0d_row%0d", s, i), 256'(row_m(i)), 256'(m_rows[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [239:0] exp_stb;
    logic [31:0]  c, w;
    int           s0, rl0, sh0;

    vecs[0] = '{32'h60000001, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0}; // column 12
    vecs[1] = '{32'h05000001, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0}; // opcode 5
    vecs[2] = '{32'h17000000, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0}; // opcode 7
    vecs[3] = '{32'h01000000, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0}; // desync
    vecs[4] = '{32'h02000000, 1'b1, 32'h02000000, 1'b0, 1'b0, 1'b1}; // check ok
    vecs[5] = '{32'h02000000, 1'b1, 32'h02000001, 1'b1, 1'b0, 1'b0}; // check bad
    vecs[6] = '{32'hF8000003, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0}; // column 31
    vecs[7] = '{32'h58000003, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1}; // column 11
    exp_stb = '0;
    exp_stb[60] = 1'b1;
    exp_stb[62] = 1'b1;
    model_reset();

    // Reset values while reset is held.
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_ready", 256'(ready_m), 256'(0));
    chk("rst_busy", 256'(busy_m), 256'(0));
    chk("rst_cfg_err", 256'({cfg_m, err_m}), 256'(0));
    chk("rst_frames", 256'(frames_m), 256'(0));
    chk("rst_fdata", 256'(fdata_m[255:0] | fdata_m[511:256] | 256'(fdata_m[575:512])), 256'(0));
    chk("rst_stb", 256'(stb_m), 256'(0));
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 256'(ready_m), 256'(1));

    // Column 3, mask 5, words 0..17, then desync.
    send(0, START);
    send(0, 32'h18000005);
    for (int r = 0; r < 18; r++) send(0, 32'(r));
    chk("p_stb_pattern", 256'(stb_m), 256'(exp_stb));
    chk("p_ready_low", 256'(ready_m), 256'(0));
    chk("p_row17_in_stb", 256'(row_m(17)), 256'(0));
    chk("p_row0_in_stb", 256'(row_m(0)), 256'(17));
    @(negedge clk);
    chk("p_stb_one_cycle", 256'(stb_m), 256'(0));
    chk("p_frames", 256'(frames_m), 256'(1));
    send(0, 32'h01000000);
    chk("p_configured", 256'(cfg_m), 256'(1));
    chk("p_busy", 256'(busy_m), 256'(0));
    chk("p_err", 256'(err_m), 256'(0));

    // Header vectors: each after a fresh start word, then an abort.
    for (int i = 0; i < 8; i++) begin
      s0 = mon_stb_cycles;
      send(0, START);
      send(0, vecs[i].hdr);
      if (vecs[i].has_pl) send(0, vecs[i].pl);
      chk($sformatf("v%0d_err", i), 256'(err_m), 256'(vecs[i].e_err));
      chk($sformatf("v%0d_cfg", i), 256'(cfg_m), 256'(vecs[i].e_cfg));
      chk($sformatf("v%0d_busy", i), 256'(busy_m), 256'(vecs[i].e_busy));
      chk($sformatf("v%0d_frames", i), 256'(frames_m), 256'(0));
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_no_stb", i), 256'(mon_stb_cycles - s0), 256'(0));
      abort_pulse();
      chk($sformatf("v%0d_abort_busy", i), 256'(busy_m), 256'(0));
      chk($sformatf("v%0d_abort_err", i), 256'(err_m), 256'(vecs[i].e_err));
      chk($sformatf("v%0d_abort_cfg", i), 256'(cfg_m), 256'(vecs[i].e_cfg));
    end

    // Write + CHECK with correct (k=0) and corrupted (k=1) checksum, then desync.
    for (int k = 0; k < 2; k++) begin
      send(0, START);
      c = '0;
      send(0, 32'h280FFFFF);
      c = fold(c, 32'h280FFFFF);
      for (int r = 0; r < 18; r++) begin
        w = $urandom();
        send(0, w);
        c = fold(c, w);
      end
      send(0, 32'h02000000);
      c = fold(c, 32'h02000000);
      send(0, (k == 1) ? (c ^ 32'h80000000) : c);
      send(0, 32'h01000000);
      chk($sformatf("chk%0d_cfg", k), 256'(cfg_m), 256'(k == 0));
      chk($sformatf("chk%0d_err", k), 256'(err_m), 256'(k == 1));
      chk($sformatf("chk%0d_busy", k), 256'(busy_m), 256'(0));
    end

    // Abort while the word for row 9 is offered.
    s0 = mon_stb_cycles;
    send(0, START);
    send(0, 32'h10000003);
    for (int r = 0; r < 18; r++) send(0, 32'(100 + r));
    send(0, 32'h20000001);
    for (int r = 0; r < 8; r++) send(0, 32'(200 + r));
    data_i  = 32'd999;
    valid_m = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    valid_m = 1'b0;
    abort   = 1'b0;
    model_reset_phase();
    chk("ab_busy", 256'(busy_m), 256'(0));
    chk("ab_row9_kept", 256'(row_m(9)), 256'(108));
    chk("ab_row10_new", 256'(row_m(10)), 256'(207));
    chk("ab_frames", 256'(frames_m), 256'(1));
    repeat (3) @(negedge clk);
    chk("ab_one_strobe_only", 256'(mon_stb_cycles - s0), 256'(1));
    send(0, START);
    send(0, 32'h07000000);
    chk("ab_err_set", 256'(err_m), 256'(1));
    send(0, START);
    chk("ab_restart_err", 256'(err_m), 256'(0));
    chk("ab_restart_frames", 256'(frames_m), 256'(0));
    abort_pulse();

    // Three-cycle strobe instance with valid held high across the strobe.
    rl0 = mon3_rdy_low;
    sh0 = mon3_stb_high;
    send(1, START);
    send(1, 32'h18000005);
    for (int r = 0; r < 18; r++) send(1, 32'(50 + r));
    send(1, 32'h01000000);
    repeat (3) @(negedge clk);
    chk("s3_ready_low", 256'(mon3_rdy_low - rl0), 256'(3));
    chk("s3_stb_high", 256'(mon3_stb_high - sh0), 256'(3));
    chk("s3_stb_pattern", 256'(mon3_last_stb), 256'(exp_stb));
    chk("s3_cfg", 256'(cfg3), 256'(1));
    chk("s3_frames", 256'(frames3), 256'(1));
    chk("s3_err_busy", 256'({err3, busy3}), 256'(0));
    chk("s3_row17", 256'(row3(17)), 256'(50));
    chk("s3_row0", 256'(row3(0)), 256'(67));

    // Randomized streams with random valid gaps.
    gap_max = 2;
    for (int s = 0; s < 30; s++) rand_stream(s);
    gap_max = 0;

    // Asynchronous reset in the middle of a strobe.
    send(0, START);
    send(0, 32'h380ABCDE);
    for (int r = 0; r < 18; r++) send(0, $urandom());
    chk("ar_in_strobe", 256'(stb_m), 256'(m_last_stb));
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("ar_stb", 256'(stb_m), 256'(0));
    chk("ar_busy_ready", 256'({busy_m, ready_m}), 256'(0));
    chk("ar_cfg_err", 256'({cfg_m, err_m}), 256'(0));
    chk("ar_frames", 256'(frames_m), 256'(0));
    chk("ar_fdata", 256'(fdata_m[255:0] | fdata_m[511:256] | 256'(fdata_m[575:512])), 256'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("ar_ready_back", 256'(ready_m), 256'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
